// File: rtl/sobel_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sobel_pkg - sequencer state type and default frame geometry. Rev 1.0
// ------------------------------------------------------------------
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 240;
  localparam int DEF_HEIGHT  = 240;
  localparam int DEF_TOTAL   = DEF_WIDTH * DEF_HEIGHT;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_MAX_OUT = 8;

endpackage
`default_nettype wire

// File: rtl/raster_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// raster_addr_gen - raster x/y/address counters with edge flag. Rev 1.0
// ------------------------------------------------------------------
module raster_addr_gen
  import sobel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int TOTAL  = WIDTH * HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [7:0]        x_o,
  output logic [7:0]        y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              border_o,
  output logic              last_o
);

  localparam logic [7:0]        X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0]        Y_LAST = 8'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(TOTAL - 1);

  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Address tracks the raster position by increment, never by y*WIDTH+x.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = addr_q + 1'b1;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign addr_o   = addr_q;
  assign border_o = (x_q == 8'd0) || (x_q == X_LAST) || (y_q == 8'd0) || (y_q == Y_LAST);
  assign last_o   = (addr_q == A_LAST);

endmodule
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// sobel_frame_ctrl - frame sequencer: issue, credit, write-back. Rev 1.0
// ------------------------------------------------------------------
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int TOTAL   = WIDTH * HEIGHT,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_x,
  output logic [7:0]        pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_border,
  input  logic              res_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              err,
  output logic [31:0]       total_cycles_out
);

  localparam int                OUT_W     = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(TOTAL - 1);

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              err_q, err_d;
  logic              in_run, in_busy, hs, accept_start, final_wr;
  logic              last_pix, raw_border;

  raster_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .TOTAL  (TOTAL),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept_start),
    .adv_i    (hs),
    .x_o      (pix_x),
    .y_o      (pix_y),
    .addr_o   (pix_addr),
    .border_o (raw_border),
    .last_o   (last_pix)
  );

  always_comb begin
    in_run       = (state_q == RUN);
    in_busy      = in_run || (state_q == DRAIN);
    pix_valid    = in_run && (out_q < MAX_OUT_C);
    hs           = pix_valid && pix_ready;
    // A result with no credit outstanding is a protocol error, never a write.
    wr_en        = in_busy && res_valid && (out_q != '0);
    accept_start = start && ((state_q == IDLE) || (state_q == DONE));
    final_wr     = wr_en && (wr_addr_q == WR_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (final_wr)             state_d = DONE;
        else if (hs && last_pix)  state_d = DRAIN;
      end
      DRAIN:   if (final_wr) state_d = DONE;
      default: state_d = IDLE;
    endcase

    out_d = out_q;
    if (accept_start)          out_d = '0;
    else if (hs && !wr_en)     out_d = out_q + 1'b1;
    else if (!hs && wr_en)     out_d = out_q - 1'b1;

    wr_addr_d = wr_addr_q;
    if (accept_start)  wr_addr_d = '0;
    else if (wr_en)    wr_addr_d = wr_addr_q + 1'b1;

    cyc_d = cyc_q;
    if (accept_start)                            cyc_d = '0;
    else if (in_busy && (cyc_q != 32'hFFFF_FFFF)) cyc_d = cyc_q + 32'd1;

    err_d = err_q | (res_valid && !wr_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= '0;
      wr_addr_q <= '0;
      cyc_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      wr_addr_q <= wr_addr_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
    end
  end

  assign busy             = in_busy;
  assign done             = (state_q == DONE);
  assign pix_border       = raw_border && in_run;
  assign wr_addr          = wr_addr_q;
  assign err              = err_q;
  assign total_cycles_out = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sobel_frame_ctrl - model-checked bench for the frame sequencer. Rev 1.0
// ------------------------------------------------------------------
module tb_sobel_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int T  = 12;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start, pix_ready, res_valid, sel;

  logic a_busy, a_done, a_pv, a_pb, a_wr, a_err;
  logic b_busy, b_done, b_pv, b_pb, b_wr, b_err;
  logic [7:0] a_x, a_y, b_x, b_y;
  logic [AW-1:0] a_addr, a_wa, b_addr, b_wa;
  logic [31:0] a_cyc, b_cyc;

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .TOTAL(T), .ADDR_W(AW), .MAX_OUT(8)) dut_a (
    .clk(clk), .rst(rst_a), .start(start), .busy(a_busy), .done(a_done),
    .pix_valid(a_pv), .pix_ready(pix_ready), .pix_x(a_x), .pix_y(a_y),
    .pix_addr(a_addr), .pix_border(a_pb), .res_valid(res_valid), .wr_en(a_wr),
    .wr_addr(a_wa), .err(a_err), .total_cycles_out(a_cyc));

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .TOTAL(T), .ADDR_W(AW), .MAX_OUT(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(start), .busy(b_busy), .done(b_done),
    .pix_valid(b_pv), .pix_ready(pix_ready), .pix_x(b_x), .pix_y(b_y),
    .pix_addr(b_addr), .pix_border(b_pb), .res_valid(res_valid), .wr_en(b_wr),
    .wr_addr(b_wa), .err(b_err), .total_cycles_out(b_cyc));

  logic d_busy, d_done, d_pv, d_pb, d_wr, d_err;
  logic [7:0] d_x, d_y;
  logic [AW-1:0] d_addr, d_wa;
  logic [31:0] d_cyc;
  logic rst_sel;

  always_comb begin
    {d_busy, d_done, d_pv, d_pb, d_wr, d_err, d_x, d_y, d_addr, d_wa, d_cyc} = sel ?
      {b_busy, b_done, b_pv, b_pb, b_wr, b_err, b_x, b_y, b_addr, b_wa, b_cyc} :
      {a_busy, a_done, a_pv, a_pb, a_wr, a_err, a_x, a_y, a_addr, a_wa, a_cyc};
    rst_sel = sel ? rst_b : rst_a;
  end

  // Frame model: counts of pixels issued and results written drive everything.
  int     m_max;
  bit     m_active, m_fin, m_err, m_hs_last;
  int     m_iss, m_wrn, m_out;
  longint m_cyc;
  logic   e_run, e_pv, e_wr, e_pb;
  int     e_x, e_y;

  always_comb begin
    e_run = m_active && (m_iss < T);
    e_pv  = e_run && (m_out < m_max);
    e_wr  = m_active && res_valid && (m_out > 0);
    e_x   = m_iss % W;
    e_y   = m_iss / W;
    e_pb  = e_run && ((e_x == 0) || (e_x == W - 1) || (e_y == 0) || (e_y == H - 1));
  end

  always @(posedge clk) begin
    bit hs, wr;
    hs = e_pv && pix_ready;
    wr = e_wr;
    if (rst_sel) begin
      m_active = 0; m_fin = 0; m_err = 0; m_hs_last = 0;
      m_iss = 0; m_wrn = 0; m_out = 0; m_cyc = 0;
    end else begin
      if (res_valid && !wr) m_err = 1;
      if (m_active) begin
        if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
        m_iss = m_iss + int'(hs);
        m_wrn = m_wrn + int'(wr);
        m_out = m_out + int'(hs) - int'(wr);
        if (m_wrn == T) begin m_active = 0; m_fin = 1; end
      end else if (start) begin
        m_active = 1; m_fin = 0;
        m_iss = 0; m_wrn = 0; m_out = 0; m_cyc = 0;
      end
      m_hs_last = hs;
    end
  end

  int n_chk = 0, n_pass = 0;
  bit cmp_en, rnd_ready, inject;
  int dly;
  logic [15:0] pipe;
  logic [7:0] cap_x [0:31];
  logic [7:0] cap_y [0:31];
  logic [AW-1:0] cap_a [0:31];
  logic cap_b [0:31];
  int cap_n, n_wr, max_fl;
  logic [11:0] bexp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic compare();
    chk("busy",       64'(d_busy), 64'(m_active));
    chk("done",       64'(d_done), 64'(m_fin));
    chk("pix_valid",  64'(d_pv),   64'(e_pv));
    chk("pix_x",      64'(d_x),    64'(e_x));
    chk("pix_y",      64'(d_y),    64'(e_y));
    chk("pix_addr",   64'(d_addr), 64'(m_iss));
    chk("pix_border", 64'(d_pb),   64'(e_pb));
    chk("wr_en",      64'(d_wr),   64'(e_wr));
    chk("wr_addr",    64'(d_wa),   64'(m_wrn));
    chk("err",        64'(d_err),  64'(m_err));
    chk("cycles",     64'(d_cyc),  64'(m_cyc));
  endtask

  task automatic tick();
    @(negedge clk);
    if (cmp_en) compare();
    if (d_pv && pix_ready && cap_n < 32) begin
      cap_x[cap_n] = d_x; cap_y[cap_n] = d_y; cap_a[cap_n] = d_addr; cap_b[cap_n] = d_pb;
      cap_n++;
    end
    if (d_wr) n_wr++;
    if (cap_n - n_wr > max_fl) max_fl = cap_n - n_wr;
    @(posedge clk);
    #1;
    pipe      = {pipe[14:0], m_hs_last};
    res_valid = inject || pipe[dly-1];
    pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic check_zero(input string tag);
    #1;
    chk({tag, "_busy"},   64'(d_busy), 64'd0);
    chk({tag, "_done"},   64'(d_done), 64'd0);
    chk({tag, "_pv"},     64'(d_pv),   64'd0);
    chk({tag, "_addr"},   64'(d_addr), 64'd0);
    chk({tag, "_border"}, 64'(d_pb),   64'd0);
    chk({tag, "_wr_en"},  64'(d_wr),   64'd0);
    chk({tag, "_wraddr"}, 64'(d_wa),   64'd0);
    chk({tag, "_err"},    64'(d_err),  64'd0);
    chk({tag, "_cycles"}, 64'(d_cyc),  64'd0);
  endtask

  task automatic run_frame(input string tag, input bit pulses, input int budget);
    cap_n = 0; n_wr = 0; max_fl = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < budget && !m_fin; i++) begin
      start = pulses && (i == 3 || i == 8);
      tick();
      start = 1'b0;
    end
    #1;
    chk({tag, "_done"},   64'(d_done), 64'd1);
    chk({tag, "_writes"}, 64'(n_wr),   64'(T));
    chk({tag, "_wraddr"}, 64'(d_wa),   64'(T));
    chk({tag, "_count"},  64'(cap_n),  64'(T));
    for (int i = 0; i < T && i < cap_n; i++) begin
      chk({tag, "_seq_addr"},   64'(cap_a[i]), 64'(i));
      chk({tag, "_seq_x"},      64'(cap_x[i]), 64'(i % W));
      chk({tag, "_seq_y"},      64'(cap_y[i]), 64'(i / W));
      chk({tag, "_seq_border"}, 64'(cap_b[i]), 64'(bexp[i]));
    end
  endtask

  initial begin
    bexp = 12'b1111_1001_1111;
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; start = 1'b0; pix_ready = 1'b1;
    res_valid = 1'b0; inject = 1'b0; pipe = '0; dly = 2; m_max = 8; rnd_ready = 1'b0;
    cmp_en = 1'b0; cap_n = 0; n_wr = 0; max_fl = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    tick();
    check_zero("reset");
    rst_a = 1'b0;
    tick();

    run_frame("f1", 1'b0, 100);
    chk("f1_cycles", 64'(d_cyc), 64'd14);
    chk("model_cycles", 64'(m_cyc), 64'd14);

    run_frame("f2", 1'b1, 100);
    chk("f2_cycles", 64'(d_cyc), 64'd14);

    rst_a = 1'b1; pipe = '0;
    tick();
    rst_a = 1'b0;
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    #1;
    chk("idle_res_wr_en", 64'(d_wr), 64'd0);
    tick();
    #1;
    chk("idle_res_err", 64'(d_err), 64'd1);
    chk("idle_res_wraddr", 64'(d_wa), 64'd0);
    repeat (3) tick();
    chk("err_sticky", 64'(d_err), 64'd1);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && m_iss != 7; i++) tick();
    #1;
    chk("rst_at_addr", 64'(d_addr), 64'd7);
    rst_a = 1'b1; pipe = '0;
    tick();
    check_zero("midrst");
    rst_a = 1'b0;
    tick();
    run_frame("f3", 1'b0, 100);
    chk("f3_cycles", 64'(d_cyc), 64'd14);

    rnd_ready = 1'b1;
    run_frame("rnd", 1'b0, 400);
    rnd_ready = 1'b0;

    rst_a = 1'b1; rst_b = 1'b1; pipe = '0;
    tick();
    sel = 1'b1; m_max = 2; dly = 5;
    tick();
    rst_b = 1'b0;
    tick();
    run_frame("credit", 1'b0, 200);
    chk("credit_max_inflight", 64'(max_fl), 64'd2);
    chk("credit_cycles", 64'(d_cyc), 64'd37);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
